// File: rtl/ctrl_pkg.sv
// Shared constants, control bundle types and forwarding helper used by the
// ID/EX/MEM/WB control pipeline and the main decoder.
package ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Opcodes shared with the main decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // EX/MEM wins over MEM/WB because it holds the younger result
  function automatic logic [1:0] fwd_sel(
    input logic       mem_we,
    input logic [4:0] mem_addr,
    input logic       wb_we,
    input logic [4:0] wb_addr,
    input logic [4:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_addr != 5'd0) && (mem_addr == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_addr != 5'd0) && (wb_addr == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational EX operand forwarding selects for both ALU operands.
module forward_unit
  import ctrl_pkg::*;
(
  input  logic       mem_reg_write,
  input  logic [4:0] mem_wb_addr,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_wb_addr,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  assign forward_a = fwd_sel(mem_reg_write, mem_wb_addr, wb_reg_write, wb_wb_addr, ex_rs);
  assign forward_b = fwd_sel(mem_reg_write, mem_wb_addr, wb_reg_write, wb_wb_addr, ex_rt);

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline of the 5-stage MIPS core: ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall with bubble insertion, IF flush and forwarding.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   RegDst_i,
  input  logic                   ALUSrc_i,
  input  logic                   MemRead_i,
  input  logic                   MemWrite_i,
  input  logic                   RegWrite_i,
  input  logic                   MemToReg_i,
  input  logic                   Jump_i,
  input  logic                   Branch_i,
  input  logic [1:0]             ALUOp_i,
  input  logic                   Eq_i,
  input  logic [4:0]             Rs_i,
  input  logic [4:0]             Rt_i,
  input  logic [4:0]             Rd_i,
  output logic                   PCWrite_o,
  output logic                   IFIDWrite_o,
  output logic                   IFFlush_o,
  output logic                   EX_RegDst_o,
  output logic                   EX_ALUSrc_o,
  output logic [1:0]             EX_ALUOp_o,
  output logic [4:0]             EX_Rs_o,
  output logic [4:0]             EX_Rt_o,
  output logic [4:0]             EX_Rd_o,
  output logic [1:0]             ForwardA_o,
  output logic [1:0]             ForwardB_o,
  output logic                   MEM_MemRead_o,
  output logic                   MEM_MemWrite_o,
  input  logic [4:0]             MEM_WBAddr_i,
  output logic                   WB_RegWrite_o,
  output logic                   WB_MemToReg_o,
  output logic [4:0]             WB_WBAddr_o,
  output logic [STALL_CNT_W-1:0] StallCnt_o
);

  logic                   hazard;
  ex_ctrl_t               id_ctrl;
  ex_ctrl_t               ex_ctrl;
  mem_ctrl_t              mem_ctrl;
  wb_ctrl_t               wb_ctrl;
  logic [4:0]             ex_rs;
  logic [4:0]             ex_rt;
  logic [4:0]             ex_rd;
  logic [4:0]             wb_addr;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign hazard = ex_ctrl.mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == Rs_i) || (ex_rt == Rt_i));

  assign PCWrite_o   = ~hazard;
  assign IFIDWrite_o = ~hazard;
  assign IFFlush_o   = ~hazard & (Jump_i | (Branch_i & Eq_i));

  // Don't-care decoder fields are forced to 0 so no stage ever holds X
  always_comb begin
    id_ctrl            = '0;
    id_ctrl.reg_dst    = RegWrite_i & RegDst_i;
    id_ctrl.alu_src    = ALUSrc_i;
    id_ctrl.alu_op     = (Branch_i | Jump_i) ? ALUOP_ADD : ALUOp_i;
    id_ctrl.mem_read   = MemRead_i;
    id_ctrl.mem_write  = MemWrite_i;
    id_ctrl.reg_write  = RegWrite_i;
    id_ctrl.mem_to_reg = RegWrite_i & MemToReg_i;
    if (hazard) begin
      id_ctrl = '0;
    end
  end

  // Register fields are captured even for a bubble; only control is zeroed
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl <= '0;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
    end else begin
      ex_ctrl <= id_ctrl;
      ex_rs   <= Rs_i;
      ex_rt   <= Rt_i;
      ex_rd   <= Rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_ctrl <= '0;
      wb_ctrl  <= '0;
      wb_addr  <= '0;
    end else begin
      mem_ctrl.mem_read   <= ex_ctrl.mem_read;
      mem_ctrl.mem_write  <= ex_ctrl.mem_write;
      mem_ctrl.reg_write  <= ex_ctrl.reg_write;
      mem_ctrl.mem_to_reg <= ex_ctrl.mem_to_reg;
      wb_ctrl.reg_write   <= mem_ctrl.reg_write;
      wb_ctrl.mem_to_reg  <= mem_ctrl.mem_to_reg;
      wb_addr             <= MEM_WBAddr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  forward_unit u_forward_unit (
    .mem_reg_write (mem_ctrl.reg_write),
    .mem_wb_addr   (MEM_WBAddr_i),
    .wb_reg_write  (wb_ctrl.reg_write),
    .wb_wb_addr    (wb_addr),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .forward_a     (ForwardA_o),
    .forward_b     (ForwardB_o)
  );

  assign EX_RegDst_o    = ex_ctrl.reg_dst;
  assign EX_ALUSrc_o    = ex_ctrl.alu_src;
  assign EX_ALUOp_o     = ex_ctrl.alu_op;
  assign EX_Rs_o        = ex_rs;
  assign EX_Rt_o        = ex_rt;
  assign EX_Rd_o        = ex_rd;
  assign MEM_MemRead_o  = mem_ctrl.mem_read;
  assign MEM_MemWrite_o = mem_ctrl.mem_write;
  assign WB_RegWrite_o  = wb_ctrl.reg_write;
  assign WB_MemToReg_o  = wb_ctrl.mem_to_reg;
  assign WB_WBAddr_o    = wb_addr;
  assign StallCnt_o     = stall_cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed self-checking bench for ctrl_pipeline, built with a 2-bit stall
// counter so saturation is reachable in a few stalls.
module tb_ctrl_pipeline;

  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i;
  logic          RegWrite_i, MemToReg_i, Jump_i, Branch_i, Eq_i;
  logic [1:0]    ALUOp_i;
  logic [4:0]    Rs_i, Rt_i, Rd_i, MEM_WBAddr_i;
  logic          PCWrite_o, IFIDWrite_o, IFFlush_o;
  logic          EX_RegDst_o, EX_ALUSrc_o;
  logic [1:0]    EX_ALUOp_o, ForwardA_o, ForwardB_o;
  logic [4:0]    EX_Rs_o, EX_Rt_o, EX_Rd_o, WB_WBAddr_o;
  logic          MEM_MemRead_o, MEM_MemWrite_o, WB_RegWrite_o, WB_MemToReg_o;
  logic [CW-1:0] StallCnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ctrl_pipeline #(.STALL_CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .Jump_i(Jump_i), .Branch_i(Branch_i), .ALUOp_i(ALUOp_i), .Eq_i(Eq_i),
    .Rs_i(Rs_i), .Rt_i(Rt_i), .Rd_i(Rd_i),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .IFFlush_o(IFFlush_o),
    .EX_RegDst_o(EX_RegDst_o), .EX_ALUSrc_o(EX_ALUSrc_o), .EX_ALUOp_o(EX_ALUOp_o),
    .EX_Rs_o(EX_Rs_o), .EX_Rt_o(EX_Rt_o), .EX_Rd_o(EX_Rd_o),
    .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
    .MEM_MemRead_o(MEM_MemRead_o), .MEM_MemWrite_o(MEM_MemWrite_o),
    .MEM_WBAddr_i(MEM_WBAddr_i),
    .WB_RegWrite_o(WB_RegWrite_o), .WB_MemToReg_o(WB_MemToReg_o),
    .WB_WBAddr_o(WB_WBAddr_o), .StallCnt_o(StallCnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic reg_dst, input logic alu_src, input logic mem_read,
                        input logic mem_write, input logic reg_write, input logic mem_to_reg,
                        input logic jump, input logic branch, input logic [1:0] alu_op,
                        input logic eq, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    RegDst_i = reg_dst; ALUSrc_i = alu_src; MemRead_i = mem_read; MemWrite_i = mem_write;
    RegWrite_i = reg_write; MemToReg_i = mem_to_reg; Jump_i = jump; Branch_i = branch;
    ALUOp_i = alu_op; Eq_i = eq; Rs_i = rs; Rt_i = rt; Rd_i = rd;
    #1;
  endtask

  task automatic set_nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_id(0, 1, 1, 0, 1, 1, 0, 0, 2'b00, 0, rs, rt, 5'd0);
  endtask

  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    set_id(1, 0, 0, 0, 1, 0, 0, 0, 2'b10, 0, rs, rt, rd);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      set_nop();
      MEM_WBAddr_i = 5'd0;
      tick();
    end
  endtask

  task automatic test_reset();
    set_nop();
    MEM_WBAddr_i = 5'd0;
    #12;
    checks++; if (EX_ALUSrc_o !== 1'b0 || MEM_MemRead_o !== 1'b0 || WB_RegWrite_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stages: ex_alusrc=%b mem_read=%b wb_we=%b required 0", EX_ALUSrc_o, MEM_MemRead_o, WB_RegWrite_o); end
    checks++; if (PCWrite_o !== 1'b1 || IFIDWrite_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_enables: pcw=%b ifidw=%b required 1", PCWrite_o, IFIDWrite_o); end
    checks++; if (StallCnt_o !== 2'd0 || ForwardA_o !== 2'b00 || ForwardB_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_cnt_fwd: cnt=%0d fa=%b fb=%b required 0/00/00", StallCnt_o, ForwardA_o, ForwardB_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    set_lw(5'd1, 5'd2);
    tick();
    set_add(5'd2, 5'd4, 5'd3);
    tick();
    set_nop();
    checks++; if (MEM_MemRead_o !== 1'b1 || StallCnt_o !== 2'd1) begin errors++; $display("[TB] FAIL pre_reset_state: mem_read=%b cnt=%0d required 1/1", MEM_MemRead_o, StallCnt_o); end
    rst_i = 1'b0;
    #1;
    checks++; if (MEM_MemRead_o !== 1'b0 || EX_Rs_o !== 5'd0 || StallCnt_o !== 2'd0) begin errors++; $display("[TB] FAIL async_reset: mem_read=%b ex_rs=%0d cnt=%0d required 0/0/0", MEM_MemRead_o, EX_Rs_o, StallCnt_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_pipeline_flow();
    nops(2);
    set_lw(5'd1, 5'd2);
    tick();
    set_nop();
    checks++; if (EX_ALUSrc_o !== 1'b1 || EX_Rt_o !== 5'd2) begin errors++; $display("[TB] FAIL flow_ex: alusrc=%b rt=%0d required 1/2", EX_ALUSrc_o, EX_Rt_o); end
    tick();
    MEM_WBAddr_i = 5'd2;
    #1;
    checks++; if (MEM_MemRead_o !== 1'b1 || EX_ALUSrc_o !== 1'b0) begin errors++; $display("[TB] FAIL flow_mem: mem_read=%b ex_alusrc=%b required 1/0", MEM_MemRead_o, EX_ALUSrc_o); end
    tick();
    MEM_WBAddr_i = 5'd0;
    #1;
    checks++; if (WB_MemToReg_o !== 1'b1 || WB_RegWrite_o !== 1'b1 || WB_WBAddr_o !== 5'd2) begin errors++; $display("[TB] FAIL flow_wb: m2r=%b we=%b addr=%0d required 1/1/2", WB_MemToReg_o, WB_RegWrite_o, WB_WBAddr_o); end
  endtask

  task automatic test_load_use();
    nops(3);
    set_lw(5'd1, 5'd2);
    tick();
    set_add(5'd2, 5'd4, 5'd3);
    checks++; if (PCWrite_o !== 1'b0 || IFIDWrite_o !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall: pcw=%b ifidw=%b required 0/0", PCWrite_o, IFIDWrite_o); end
    tick();
    MEM_WBAddr_i = 5'd2;
    #1;
    checks++; if (EX_RegDst_o !== 1'b0 || EX_ALUOp_o !== 2'b00 || EX_Rs_o !== 5'd2) begin errors++; $display("[TB] FAIL lu_bubble: regdst=%b aluop=%b rs=%0d required 0/00/2", EX_RegDst_o, EX_ALUOp_o, EX_Rs_o); end
    checks++; if (PCWrite_o !== 1'b1 || StallCnt_o !== 2'd1) begin errors++; $display("[TB] FAIL lu_one_cycle: pcw=%b cnt=%0d required 1/1", PCWrite_o, StallCnt_o); end
    tick();
    set_nop();
    MEM_WBAddr_i = 5'd0;
    #1;
    checks++; if (EX_RegDst_o !== 1'b1 || EX_ALUOp_o !== 2'b10 || ForwardA_o !== 2'b01 || ForwardB_o !== 2'b00) begin errors++; $display("[TB] FAIL lu_forward: regdst=%b aluop=%b fa=%b fb=%b required 1/10/01/00", EX_RegDst_o, EX_ALUOp_o, ForwardA_o, ForwardB_o); end
  endtask

  task automatic test_stall_flush();
    nops(3);
    set_lw(5'd1, 5'd7);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 1, 5'd7, 5'd8, 5'd0);
    checks++; if (IFFlush_o !== 1'b0 || PCWrite_o !== 1'b0) begin errors++; $display("[TB] FAIL sf_stall: flush=%b pcw=%b required 0/0", IFFlush_o, PCWrite_o); end
    tick();
    checks++; if (IFFlush_o !== 1'b1 || PCWrite_o !== 1'b1) begin errors++; $display("[TB] FAIL sf_flush: flush=%b pcw=%b required 1/1", IFFlush_o, PCWrite_o); end
    tick();
    set_nop();
    checks++; if (EX_ALUOp_o !== 2'b00 || EX_Rs_o !== 5'd7 || StallCnt_o !== 2'd2) begin errors++; $display("[TB] FAIL sf_branch_ex: aluop=%b rs=%0d cnt=%0d required 00/7/2", EX_ALUOp_o, EX_Rs_o, StallCnt_o); end
  endtask

  task automatic test_forwarding();
    nops(3);
    set_add(5'd1, 5'd1, 5'd5);
    tick();
    set_add(5'd1, 5'd1, 5'd5);
    tick();
    set_add(5'd5, 5'd6, 5'd9);
    MEM_WBAddr_i = 5'd5;
    tick();
    set_nop();
    MEM_WBAddr_i = 5'd5;
    #1;
    checks++; if (ForwardA_o !== 2'b10 || ForwardB_o !== 2'b00) begin errors++; $display("[TB] FAIL fwd_priority: fa=%b fb=%b required 10/00", ForwardA_o, ForwardB_o); end
    nops(3);
    set_add(5'd1, 5'd1, 5'd0);
    tick();
    set_add(5'd1, 5'd1, 5'd0);
    tick();
    set_add(5'd0, 5'd0, 5'd9);
    tick();
    set_nop();
    checks++; if (ForwardA_o !== 2'b00 || ForwardB_o !== 2'b00) begin errors++; $display("[TB] FAIL fwd_zero_reg: fa=%b fb=%b required 00/00", ForwardA_o, ForwardB_o); end
    nops(3);
    set_add(5'd1, 5'd1, 5'd6);
    tick();
    nops(1);
    set_add(5'd0, 5'd6, 5'd9);
    MEM_WBAddr_i = 5'd6;
    tick();
    set_nop();
    MEM_WBAddr_i = 5'd6;
    #1;
    checks++; if (ForwardB_o !== 2'b01 || ForwardA_o !== 2'b00) begin errors++; $display("[TB] FAIL fwd_memwb_b: fa=%b fb=%b required 00/01", ForwardA_o, ForwardB_o); end
  endtask

  task automatic test_sanitise();
    nops(3);
    set_id(1'bx, 1, 0, 1, 0, 1'bx, 0, 0, 2'b00, 0, 5'd1, 5'd2, 5'd0);
    tick();
    set_nop();
    checks++; if (EX_RegDst_o !== 1'b0 || EX_ALUSrc_o !== 1'b1) begin errors++; $display("[TB] FAIL san_ex: regdst=%b alusrc=%b required 0/1", EX_RegDst_o, EX_ALUSrc_o); end
    tick();
    checks++; if (MEM_MemWrite_o !== 1'b1) begin errors++; $display("[TB] FAIL san_mem: memwrite=%b required 1", MEM_MemWrite_o); end
    tick();
    checks++; if (WB_MemToReg_o !== 1'b0 || WB_RegWrite_o !== 1'b0) begin errors++; $display("[TB] FAIL san_wb: m2r=%b we=%b required 0/0", WB_MemToReg_o, WB_RegWrite_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      nops(2);
      set_lw(5'd0, 5'd3);
      tick();
      set_add(5'd3, 5'd1, 5'd4);
      checks++; if (PCWrite_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall_%0d: pcw=%b required 0", i, PCWrite_o); end
      tick();
      checks++; if (PCWrite_o !== 1'b1 || StallCnt_o !== 2'd3) begin errors++; $display("[TB] FAIL b2b_sat_%0d: pcw=%b cnt=%0d required 1/3", i, PCWrite_o, StallCnt_o); end
    end
  endtask

  initial begin
    MEM_WBAddr_i = 5'd0;
    $display("[TB] ctrl_pipeline directed test start");
    test_reset();
    test_pipeline_flow();
    test_load_use();
    test_stall_flush();
    test_forwarding();
    test_sanitise();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Carries the decoded control bundle from the ID-stage main decoder through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core. It delivers per-stage control to EX, MEM and WB. It owns load-use hazard detection (stall plus bubble insertion), IF flush on taken branch or jump, and EX operand forwarding selects. It is the consumer end of the main decoder's control interface.

## Interface
Parameters
- STALL_CNT_W, 16, width of the saturating bubble counter.

Ports
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i, Jump_i, Branch_i  in  1 each  decoder outputs for the ID instruction. May carry X for don't-care fields.
- ALUOp_i  in  2  decoder ALU class.
- Eq_i  in  1  ID-stage register compare result (rs == rt).
- Rs_i, Rt_i, Rd_i  in  5 each  register fields of the ID instruction.
- PCWrite_o, IFIDWrite_o  out  1  enable for the PC and IF/ID registers. Low during a stall.
- IFFlush_o  out  1  zero the IF/ID instruction.
- EX_RegDst_o, EX_ALUSrc_o  out  1  EX-stage control.
- EX_ALUOp_o  out  2  EX-stage ALU class.
- EX_Rs_o, EX_Rt_o, EX_Rd_o  out  5  register fields held in ID/EX.
- ForwardA_o, ForwardB_o  out  2  EX operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- MEM_MemRead_o, MEM_MemWrite_o  out  1  MEM-stage control.
- MEM_WBAddr_i  in  5  EX/MEM destination register, computed by the datapath mux.
- WB_RegWrite_o, WB_MemToReg_o  out  1  WB-stage control.
- WB_WBAddr_o  out  5  MEM/WB destination register.
- StallCnt_o  out  STALL_CNT_W  number of bubbles inserted.

## Operation
**Sanitising**
- The control bundle is registered into ID/EX.
- When RegWrite_i=0, RegDst and MemToReg are captured as 0.
- When Branch_i or Jump_i is 1, ALUOp is captured as 00.
- Stage registers therefore never hold X.

**Load-use hazard**
- Condition: hazard = EX_MemRead & (EX_Rt != 0) & (EX_Rt == Rs_i | EX_Rt == Rt_i).
- On hazard: PCWrite_o=0, IFIDWrite_o=0, and ID/EX captures all-zero control (bubble).
- Register fields are still captured. StallCnt_o increments, saturating at all-ones.

**Flush**
- IFFlush_o = ~hazard & (Jump_i | (Branch_i & Eq_i)).
- Hazard has priority: while stalled, the branch or jump is re-evaluated next cycle with no flush.

**Stage advance**
- EX/MEM and MEM/WB always advance; stalls never freeze them.
- WB_WBAddr_o takes MEM_WBAddr_i.

**Forwarding (A; B identical using EX_Rt)**
- 10 if MEM_RegWrite & MEM_WBAddr_i != 0 & MEM_WBAddr_i == EX_Rs.
- Else 01 if WB_RegWrite & WB_WBAddr != 0 & WB_WBAddr == EX_Rs.
- Else 00.
- EX/MEM has priority.

**Out of scope**
- Branch operand hazards in ID are not handled here.

## Timing
- Latency: a control bundle presented in ID in cycle n drives the EX outputs in cycle n+1, MEM in n+2 and WB in n+3.
- hazard, PCWrite_o, IFIDWrite_o, IFFlush_o and ForwardA_o/ForwardB_o are combinational from current state and inputs, valid in the same cycle.
- Reset values: all stage registers 0, so every stage holds a bubble.
  - EX_*, MEM_* and WB_* outputs are 0; StallCnt_o is 0; ForwardA_o/ForwardB_o are 00.
  - PCWrite_o and IFIDWrite_o are 1; IFFlush_o follows its inputs.
- Reset mid-operation: asserting rst_i clears all registers immediately without waiting for a clock edge. In-flight instructions are discarded.
- Back-to-back load-use: a stall lasts exactly one cycle per hazard. The bubble clears EX_MemRead, so the next cycle cannot re-trigger on the same load.
- StallCnt_o wrap: never wraps; it holds at 2^STALL_CNT_W - 1.

## Structure
- Shared package ctrl_pkg holds:
  - ALUOp constants: ALUOP_ADD=00, ALUOP_RTYPE=10.
  - Forward select constants: FWD_RF=00, FWD_EXMEM=10, FWD_MEMWB=01.
  - Opcode constants shared with the main decoder.
- One sub-module, forward_unit, holds the purely combinational ForwardA/B logic.
- Hazard detection, stage registers and the counter live in ctrl_pipeline.

## Test plan
- **Reset:** hold rst_i=0 mid-stream with nonzero stages → all EX/MEM/WB outputs 0 with no clock edge; StallCnt_o=0.
- **Pipeline flow:** lw at ID cycle 0 (RegWrite=1, MemRead=1, MemToReg=1, ALUSrc=1) → EX_ALUSrc_o=1 at cycle 1, MEM_MemRead_o=1 at cycle 2, WB_MemToReg_o=1 at cycle 3.
- **Load-use:** lw $2 followed by add $3,$2,$4 → one cycle with PCWrite_o=0, IFIDWrite_o=0 and a zeroed EX bubble. add then reaches EX with ForwardA_o=01. StallCnt_o=1.
- **Stall vs. flush:** beq with Eq_i=1 in ID while the EX lw targets its rs → IFFlush_o=0 in the stall cycle and IFFlush_o=1 in the following cycle.
- **Forward priority and $0:** both MEM and WB write $5 and EX_Rs=5 → ForwardA_o=10. Writes to $0 → ForwardA_o=00.
- **Sanitising and saturation:** sw with RegDst_i=X → EX_RegDst_o=0. With STALL_CNT_W=2, four load-use stalls → StallCnt_o=3.
